// File: rtl/uartin.sv
// UART receiver: 8N1 frames, MSB first, CDIV clocks per bit, with an active-low
// valid_n/ready_n output handshake plus framing-error and overrun pulses.
module uartin #(
  parameter int CDIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid_n,
  input  logic       ready_n,
  output logic       frame_err,
  output logic       overrun
);

  localparam int HALF = CDIV / 2;
  localparam int CW   = $clog2(CDIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] CDIV_M1 = CW'(CDIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    sync_reg;
  logic          rx_s;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shreg_reg, shreg_next;
  logic          tick;
  logic          stop_ok, stop_bad, xfer;

  // Two-flop synchroniser; rx is asynchronous to clk.
  always_ff @(posedge clk) begin
    if (rst) sync_reg <= 2'b11;
    else     sync_reg <= {sync_reg[0], rx};
  end
  assign rx_s = sync_reg[1];
  assign tick = (cnt_reg == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= 3'd0;
      shreg_reg <= 8'h00;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shreg_reg <= shreg_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shreg_next = shreg_reg;
    if (state_reg != IDLE) cnt_next = tick ? CDIV_M1 : cnt_reg - 1'b1;
    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          cnt_next   = HALF_M1;
        end
      end
      START: begin
        // A start bit that has gone high again by mid-bit is treated as a glitch.
        if (tick) begin
          if (!rx_s) begin
            state_next = DATA;
            bit_next   = 3'd7;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shreg_next = {shreg_reg[6:0], rx_s};
          if (bit_reg == 3'd0) state_next = STOP;
          else                 bit_next   = bit_reg - 3'd1;
        end
      end
      STOP: begin
        if (tick) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stop_ok  = (state_reg == STOP) && tick && rx_s;
    stop_bad = (state_reg == STOP) && tick && !rx_s;
    xfer     = !valid_n && !ready_n;
  end

  // A transfer on the same edge as a delivery frees the slot for the new byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      data      <= 8'h00;
      valid_n   <= 1'b1;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= stop_ok && !valid_n && ready_n;
      if (stop_ok && (valid_n || xfer)) begin
        data    <= shreg_reg;
        valid_n <= 1'b0;
      end else if (xfer) begin
        valid_n <= 1'b1;
      end
    end
  end

endmodule
